alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one `alu` instance between two requesters. Each requester presents an opcode and two signed operands over a valid/ready handshake. The arbiter registers the granted operation into the ALU inputs and captures `resultAccumulator`/`flags` one cycle later. It then returns result and flags to the winning requester over a response handshake. It sits between the core's issue logic and the shared ALU datapath.

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one ALU between two
// requesters. Optional macro ALU_ARB_LOCK_EN adds per-requester lock inputs
// that let the current owner keep the ALU for back-to-back operations.
module alu_arbiter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [4:0]   req0_op,
   input  logic [4:0]   req1_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
   input  logic         req0_lock,
   input  logic         req1_lock,
`endif
   output logic [4:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_result,
   input  logic [3:0]   alu_flags,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e         state_q, state_d;
   logic           prio_q, prio_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_id_q, rsp_id_d;
   logic [W-1:0]   rsp_result_q, rsp_result_d;
   logic [3:0]     rsp_flags_q, rsp_flags_d;
   logic [4:0]     alu_op_q, alu_op_d;
   logic [W-1:0]   alu_a_q, alu_a_d;
   logic [W-1:0]   alu_b_q, alu_b_d;
`ifdef ALU_ARB_LOCK_EN
   logic           lock_on_q, lock_on_d;
   logic           lock_id_q, lock_id_d;
`endif

   logic [1:0]     req_v;
   logic           lock_hit;
   logic           gnt_any;
   logic           gnt_id;
   logic           gnt_ok;

   // Grant selection: a held lock wins, otherwise round-robin on prio.
   always_comb begin
      req_v    = {req1_valid, req0_valid};
      lock_hit = 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_hit = lock_on_q && req_v[lock_id_q];
`endif
      gnt_any  = |req_v;
      if (lock_hit) begin
`ifdef ALU_ARB_LOCK_EN
         gnt_id = lock_id_q;
`else
         gnt_id = 1'b0;
`endif
      end else if (&req_v) begin
         gnt_id = prio_q;
      end else begin
         gnt_id = req_v[1];
      end
      gnt_ok     = rst_n && (state_q == IDLE) && gnt_any;
      req0_ready = gnt_ok && !gnt_id;
      req1_ready = gnt_ok && gnt_id;
   end

   // Next-state: accept in IDLE, capture ALU outputs in EXEC, hand off in RESP.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
`ifdef ALU_ARB_LOCK_EN
      lock_on_d    = lock_on_q;
      lock_id_d    = lock_id_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef ALU_ARB_LOCK_EN
            // Owner absent in IDLE gives the lock up.
            if (lock_on_q && !req_v[lock_id_q]) lock_on_d = 1'b0;
`endif
            if (gnt_any) begin
               alu_op_d = gnt_id ? req1_op : req0_op;
               alu_a_d  = gnt_id ? req1_a  : req0_a;
               alu_b_d  = gnt_id ? req1_b  : req0_b;
               rsp_id_d = gnt_id;
               state_d  = EXEC;
               // Locked regrants leave the round-robin pointer alone.
               if (!lock_hit) prio_d = ~gnt_id;
`ifdef ALU_ARB_LOCK_EN
               lock_on_d = gnt_id ? req1_lock : req0_lock;
               lock_id_d = gnt_id;
`endif
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_on_q    <= 1'b0;
         lock_id_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
`ifdef ALU_ARB_LOCK_EN
         lock_on_q    <= lock_on_d;
         lock_id_q    <= lock_id_d;
`endif
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;

endmodule
